alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter SLICE, default 1, bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands/op presented.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 ALUOp  input  3  op code: 000 MOV, 001 NOT, 010 ADD, 011 SUB, 100 OR, 101 AND, 110/111 reserved.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 r  output  WIDTH  result.
REQ-012 c_out, zero, neg, ovf  output  1 each  status flags.

Function
REQ-013 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 IDLE: in_valid=1 captures a, b, ALUOp, clears slice counter, loads carry=1 for SUB else 0, moves to BUSY; a, b, ALUOp ignored at all other times.
REQ-015 BUSY: each cycle processes SLICE bits LSB-first, shifts result SLICE bits into r register, propagates carry; after exactly WIDTH/SLICE BUSY cycles moves to DONE.
REQ-016 Latency: out_valid rises WIDTH/SLICE clock edges after the accepting edge; minimum issue interval WIDTH/SLICE+2 cycles.
REQ-017 DONE: r and flags held stable while out_valid=1 and out_ready=0; out_ready=1 returns to IDLE on that edge.
REQ-018 MOV r=a; NOT r=~a; ADD r=a+b; SUB r=a+~b+1 (mod 2^WIDTH); OR r=a|b; AND r=a&b.
REQ-019 c_out = carry out of MSB for ADD/SUB (SUB: 1 = no borrow); 0 for all other ops.
REQ-020 Reserved ops: r=0, all flags 0, same latency and handshake as valid ops.
REQ-021 in_valid in BUSY/DONE SHALL not disturb the in-flight operation.

Reset
REQ-022 rst_n low: state=IDLE, r=0, c_out=zero=neg=ovf=0, out_valid=0, in_ready=1, counter=0, immediately and independent of clk.
REQ-023 Reset in BUSY or DONE aborts the operation; no result is delivered.

Configuration
REQ-024 Macro ALU_SEQ_FLAGS_EN defined: zero=(r==0), neg=r[WIDTH-1], ovf=carry into MSB XOR carry out of MSB for ADD/SUB (0 otherwise), all valid in DONE.
REQ-025 Macro undefined: zero, neg, ovf ports exist and are tied to 0; c_out unaffected.

Structure
REQ-026 Package alu_seq_pkg holds the ALUOp code constants and the FSM state typedef.
REQ-027 Sub-module alu_slice: combinational SLICE-bit slice (a, b, c_in, ALUOp -> r, c_out, carry into MSB bit), instantiated once.

Verification
REQ-028 WIDTH=8, SLICE=1: ADD 0xFF+0x01 -> r=0x00, c_out=1, zero=1, ovf=0; out_valid 8 edges after accept.
REQ-029 SUB 0x05-0x07 -> r=0xFE, c_out=0, neg=1, zero=0; ADD 0x7F+0x01 -> r=0x80, ovf=1, neg=1.
REQ-030 WIDTH=8, SLICE=4: a=0xA5, b=0x0F: MOV 0xA5, NOT 0x5A, OR 0xAF, AND 0x05, c_out=0; out_valid 2 edges after accept.
REQ-031 Backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 and changing a -> r/flags stable, in_ready=0, no new op accepted; out_ready=1 -> IDLE next edge.
REQ-032 rst_n low for 1 cycle mid-BUSY -> out_valid=0, r=0, in_ready=1 immediately; following ADD 0x03+0x04 -> r=0x07.
REQ-033 ALUOp=110 with a=0xFF -> r=0x00, all flags 0, same latency; repeat without ALU_SEQ_FLAGS_EN -> zero/neg/ovf always 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU: op codes, FSM states, op helpers.
package alu_seq_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // ADD and SUB are the only ops that use the carry chain.
    function automatic logic isArith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Codes 110 and 111 are reserved and produce an all-zero result.
    function automatic logic isValidOp(input logic [2:0] op);
        return op <= OP_AND;
    endfunction

endpackage

// File: rtl/alu_seq_alu_slice.sv
// Combinational SLICE-bit ALU slice. SUB inverts b here; the +1 of the
// two's complement arrives through c_i, which the top loads for SUB.
module alu_slice
    import alu_seq_pkg::*;
#(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             c_i,
    input  logic [2:0]       op_i,
    output logic [SLICE-1:0] r_o,
    output logic             c_o,
    output logic             c_msb_o
);

    logic [SLICE-1:0] bOp;
    logic [SLICE:0]   sum;

    // Slice result, carry out of the slice and carry into its top bit.
    always_comb begin
        bOp     = (op_i == OP_SUB) ? ~b_i : b_i;
        sum     = {1'b0, a_i} + {1'b0, bOp} + {{SLICE{1'b0}}, c_i};
        c_o     = isArith(op_i) ? sum[SLICE] : 1'b0;
        c_msb_o = isArith(op_i) ? (sum[SLICE-1] ^ a_i[SLICE-1] ^ bOp[SLICE-1]) : 1'b0;
        case (op_i)
            OP_MOV:  r_o = a_i;
            OP_NOT:  r_o = ~a_i;
            OP_ADD,
            OP_SUB:  r_o = sum[SLICE-1:0];
            OP_OR:   r_o = a_i | b_i;
            OP_AND:  r_o = a_i & b_i;
            default: r_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Bit-serial ALU: processes SLICE bits per cycle LSB-first with a
// valid/ready handshake on both sides. Define ALU_SEQ_FLAGS_EN to drive the
// zero/neg/ovf flags; otherwise those ports are tied to 0.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             c_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = $clog2(NSLICE) + 1;

`ifdef ALU_SEQ_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_out_q, c_out_d;
    logic             zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

    logic [SLICE-1:0] sliceR;
    logic             sliceCout, sliceCmsb;
    logic [WIDTH-1:0] sliceExt;
    logic             lastSlice;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a_i    (a_q[SLICE-1:0]),
        .b_i    (b_q[SLICE-1:0]),
        .c_i    (carry_q),
        .op_i   (op_q),
        .r_o    (sliceR),
        .c_o    (sliceCout),
        .c_msb_o(sliceCmsb)
    );

    assign lastSlice = (cnt_q == CW'(NSLICE - 1));

    // Next-state and datapath: capture in IDLE, shift slices in BUSY, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        c_out_d  = c_out_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        sliceExt = '0;
        sliceExt[SLICE-1:0] = sliceR;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = ALUOp;
                    cnt_d   = '0;
                    carry_d = (ALUOp == OP_SUB);
                    c_out_d = 1'b0;
                    zero_d  = 1'b0;
                    neg_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                r_d     = (r_q >> SLICE) | (sliceExt << (WIDTH - SLICE));
                carry_d = sliceCout;
                cnt_d   = cnt_q + 1'b1;
                if (lastSlice) begin
                    state_d = DONE;
                    c_out_d = sliceCout;
                    zero_d  = isValidOp(op_q) && (r_d == '0);
                    neg_d   = isValidOp(op_q) && r_d[WIDTH-1];
                    ovf_d   = sliceCout ^ sliceCmsb;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            op_q    <= OP_MOV;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            c_out_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            c_out_q <= c_out_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign r         = r_q;
    assign c_out     = c_out_q;
    assign zero      = FLAGS_EN ? zero_q : 1'b0;
    assign neg       = FLAGS_EN ? neg_q  : 1'b0;
    assign ovf       = FLAGS_EN ? ovf_q  : 1'b0;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: one instance with SLICE=1 and one with
// SLICE=4, each with its own scoreboard queue of expected results.
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       n;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic [2:0] op;
    logic       inValid1, inValid4, outReady1, outReady4;
    logic       inReady1, inReady4, outValid1, outValid4;
    logic [7:0] r1, r4;
    logic       c1, z1, n1, o1, c4, z4, n4, o4;

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4, held;
    int   testsRun = 0;
    int   testsFailed = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .SLICE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid1), .in_ready(inReady1),
        .a(a), .b(b), .ALUOp(op), .out_valid(outValid1), .out_ready(outReady1),
        .r(r1), .c_out(c1), .zero(z1), .neg(n1), .ovf(o1)
    );

    alu_seq #(.WIDTH(8), .SLICE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid4), .in_ready(inReady4),
        .a(a), .b(b), .ALUOp(op), .out_valid(outValid4), .out_ready(outReady4),
        .r(r4), .c_out(c4), .zero(z4), .neg(n4), .ovf(o4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model computed directly from 8-bit arithmetic.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
        exp_t e;
        logic [8:0] s;
        e = '0;
        case (o)
            OP_MOV: e.r = x;
            OP_NOT: e.r = ~x;
            OP_ADD: begin
                s = {1'b0, x} + {1'b0, y};
                e.r = s[7:0];
                e.c = s[8];
                e.o = (x[7] == y[7]) && (e.r[7] != x[7]);
            end
            OP_SUB: begin
                s = {1'b0, x} + {1'b0, ~y} + 9'd1;
                e.r = s[7:0];
                e.c = s[8];
                e.o = (x[7] != y[7]) && (e.r[7] != x[7]);
            end
            OP_OR:  e.r = x | y;
            OP_AND: e.r = x & y;
            default: e.r = 8'h00;
        endcase
`ifdef ALU_SEQ_FLAGS_EN
        if (o <= OP_AND) begin
            e.z = (e.r == 8'h00);
            e.n = e.r[7];
        end
`else
        e.o = 1'b0;
`endif
        return e;
    endfunction

    // Scoreboard for the SLICE=1 instance: compare on each delivered result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && outValid1 && outReady1) begin
            if (q1.size() == 0) begin
                checkOutput("dut1 unexpected result", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                checkOutput("dut1 r", r1, e1.r);
                checkOutput("dut1 c_out", c1, e1.c);
                checkOutput("dut1 zero", z1, e1.z);
                checkOutput("dut1 neg", n1, e1.n);
                checkOutput("dut1 ovf", o1, e1.o);
            end
        end
    end

    // Scoreboard for the SLICE=4 instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && outValid4 && outReady4) begin
            if (q4.size() == 0) begin
                checkOutput("dut4 unexpected result", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                checkOutput("dut4 r", r4, e4.r);
                checkOutput("dut4 c_out", c4, e4.c);
                checkOutput("dut4 zero", z4, e4.z);
                checkOutput("dut4 neg", n4, e4.n);
                checkOutput("dut4 ovf", o4, e4.o);
            end
        end
    end

    // Issue one op to the chosen instance and check its latency to out_valid.
    task automatic applyStimulus(input int which, input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
        int waitCnt;
        int lat;
        waitCnt = 0;
        while (!(which == 1 ? inReady1 : inReady4) && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("in_ready before issue", (which == 1) ? inReady1 : inReady4, 32'd1);
        a = x;
        b = y;
        op = o;
        if (which == 1) begin
            inValid1 = 1'b1;
            q1.push_back(model(x, y, o));
        end else begin
            inValid4 = 1'b1;
            q4.push_back(model(x, y, o));
        end
        @(posedge clk); #1;
        inValid1 = 1'b0;
        inValid4 = 1'b0;
        checkOutput("in_ready low after accept", (which == 1) ? inReady1 : inReady4, 32'd0);
        lat = 0;
        while (!(which == 1 ? outValid1 : outValid4) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", lat, (which == 1) ? 32'd8 : 32'd2);
    endtask

    // Bound the whole run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    // Directed, random, backpressure and reset sequences.
    initial begin
        int stale;
        rst_n = 1'b0;
        a = 8'h00; b = 8'h00; op = OP_MOV;
        inValid1 = 1'b0; inValid4 = 1'b0;
        outReady1 = 1'b1; outReady4 = 1'b1;
        #2;
        checkOutput("reset in_ready", inReady1, 32'd1);
        checkOutput("reset out_valid", outValid1, 32'd0);
        checkOutput("reset r", r1, 32'd0);
        checkOutput("reset flags", {c1, z1, n1, o1}, 32'd0);
        checkOutput("reset dut4 r", r4, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1, 8'hFF, 8'h01, OP_ADD);
        applyStimulus(1, 8'h05, 8'h07, OP_SUB);
        applyStimulus(1, 8'h7F, 8'h01, OP_ADD);
        applyStimulus(1, 8'hFF, 8'h00, 3'b110);
        applyStimulus(1, 8'hFF, 8'hFF, 3'b111);

        applyStimulus(4, 8'hA5, 8'h0F, OP_MOV);
        applyStimulus(4, 8'hA5, 8'h0F, OP_NOT);
        applyStimulus(4, 8'hA5, 8'h0F, OP_OR);
        applyStimulus(4, 8'hA5, 8'h0F, OP_AND);
        applyStimulus(4, 8'hFF, 8'h01, OP_ADD);
        applyStimulus(4, 8'h05, 8'h07, OP_SUB);
        applyStimulus(4, 8'hFF, 8'h00, 3'b110);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            applyStimulus(4, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
        end

        // Backpressure: hold DONE while in_valid and a keep changing.
        outReady1 = 1'b0;
        applyStimulus(1, 8'h80, 8'h80, OP_ADD);
        held = model(8'h80, 8'h80, OP_ADD);
        for (int k = 0; k < 3; k++) begin
            a = a + 8'h11;
            op = OP_SUB;
            inValid1 = 1'b1;
            @(posedge clk); #1;
            checkOutput("hold r", r1, held.r);
            checkOutput("hold flags", {c1, z1, n1, o1}, {held.c, held.z, held.n, held.o});
            checkOutput("hold in_ready", inReady1, 32'd0);
            checkOutput("hold out_valid", outValid1, 32'd1);
        end
        inValid1 = 1'b0;
        outReady1 = 1'b1;
        @(posedge clk); #1;
        checkOutput("release in_ready", inReady1, 32'd1);
        checkOutput("release out_valid", outValid1, 32'd0);
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (outValid1 || !inReady1) stale++;
        end
        checkOutput("no op accepted during hold", stale, 32'd0);

        // Reset in the middle of a SUB: nothing may be delivered.
        a = 8'h10; b = 8'h01; op = OP_SUB;
        inValid1 = 1'b1;
        @(posedge clk); #1;
        inValid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q1.delete();
        #1;
        checkOutput("abort out_valid", outValid1, 32'd0);
        checkOutput("abort r", r1, 32'd0);
        checkOutput("abort in_ready", inReady1, 32'd1);
        checkOutput("abort flags", {c1, z1, n1, o1}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1, 8'h03, 8'h04, OP_ADD);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", q1.size() + q4.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
